// File: rtl/hazard_scoreboard.sv
// Decode hazard/forwarding controller: shadow E/M/W destinations, stall_d, D/E forward selects.
// stall_d, bubble_e and d_fwd are combinational; e_fwd is registered. ext_stall freezes all state.
module hazard_scoreboard #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_stall,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic       d_early,
    input  logic [4:0] d_rd,
    input  logic       d_is_load,
    input  logic       d_is_md,
    input  logic       d_use_hilo,
    output logic       stall_d,
    output logic       bubble_e,
    output logic [1:0] d_fwd_s,
    output logic [1:0] d_fwd_t,
    output logic [1:0] e_fwd_s,
    output logic [1:0] e_fwd_t,
    output logic       md_busy
);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       is_load;
    } stage_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    stage_t           e_q;
    stage_t           m_q;
    stage_t           w_q;
    stage_t           d_stage;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             early_hz;
    logic             hilo_hz;
    logic             issue;

    function automatic logic match(input stage_t s, input logic [4:0] r);
        return s.vld && (s.rd == r) && (r != 5'd0);
    endfunction

    // A branch needs its operand now: anything in E, or a load still in M, is too late.
    function automatic logic early_src(input stage_t e, input stage_t m,
                                       input logic [4:0] r, input logic use_src);
        return use_src && (match(e, r) || (match(m, r) && m.is_load));
    endfunction

    function automatic logic [1:0] dsel(input stage_t m, input stage_t w, input logic [4:0] r);
        if (match(m, r) && !m.is_load) return FWD_M;
        if (match(w, r))               return FWD_W;
        return FWD_RF;
    endfunction

    // Evaluated one stage ahead: the E producer will sit in M, the M producer in W.
    // A W producer has already written the regfile by the time D reaches E.
    function automatic logic [1:0] esel(input stage_t e, input stage_t m,
                                        input logic [4:0] r, input logic use_src);
        if (!use_src)     return FWD_RF;
        if (match(e, r))  return FWD_M;
        if (match(m, r))  return FWD_W;
        return FWD_RF;
    endfunction

    assign load_use = d_valid && e_q.is_load &&
                      ((d_use_rs && match(e_q, d_rs)) || (d_use_rt && match(e_q, d_rt)));
    assign early_hz = d_valid && d_early &&
                      (early_src(e_q, m_q, d_rs, d_use_rs) || early_src(e_q, m_q, d_rt, d_use_rt));
    assign hilo_hz  = d_valid && d_use_hilo && (md_cnt != '0);

    assign stall_d  = load_use || early_hz || hilo_hz;
    assign bubble_e = stall_d && !ext_stall;
    assign issue    = d_valid && !stall_d;
    assign md_busy  = (md_cnt != '0);
    assign d_fwd_s  = dsel(m_q, w_q, d_rs);
    assign d_fwd_t  = dsel(m_q, w_q, d_rt);

    assign d_stage.vld     = 1'b1;
    assign d_stage.rd      = d_rd;
    assign d_stage.is_load = d_is_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_fwd_s <= FWD_RF;
            e_fwd_t <= FWD_RF;
            md_cnt  <= '0;
        end else if (!ext_stall) begin
            w_q     <= m_q;
            m_q     <= e_q;
            e_q     <= issue ? d_stage : '0;
            e_fwd_s <= issue ? esel(e_q, m_q, d_rs, d_use_rs) : FWD_RF;
            e_fwd_t <= issue ? esel(e_q, m_q, d_rt, d_use_rt) : FWD_RF;
            if (issue && d_is_md)
                md_cnt <= CNT_W'(MD_LATENCY);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule
